sopc_mem_byte_loader: RTL and testbench
=======================================

Name: sopc_mem_byte_loader

Overview:
- Upstream feeder for the 4096x32 single-port on-chip RAM slave.
- Accepts a byte stream (valid/ready) from a host link such as a UART or SPI bridge.
- Packs bytes little-endian into 32-bit words and writes each word into the RAM with auto-increment addressing and per-byte byteenable.
- A control pulse arms one transfer of N bytes starting at a word address; busy/done report progress to the control CPU.

Parameters:
- ADDR_W, 12, RAM word-address width; RAM depth is 2**ADDR_W words.
- LEN_W, 15, byte-count width; must be at least ADDR_W+3 so that a full-RAM length (16384 bytes) is representable.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cfg_start  in  1  single-cycle pulse; arms a transfer
- cfg_base_addr  in  ADDR_W  first word address, sampled on cfg_start
- cfg_len_bytes  in  LEN_W  byte count, sampled on cfg_start
- s_data  in  8  stream byte
- s_valid  in  1  stream byte valid
- s_ready  out  1  loader accepts byte this cycle
- mem_address  out  ADDR_W  RAM word address
- mem_byteenable  out  4  lanes written
- mem_chipselect  out  1  RAM select
- mem_write  out  1  RAM write strobe
- mem_writedata  out  32  packed word
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse when the final word write is issued (or immediately for len 0)
- words_written  out  ADDR_W+1  words written in the current/last transfer

Behaviour:
- Reset values: all outputs 0, state IDLE, internal byte lane index 0.
- States:
  - IDLE: s_ready=0. On cfg_start, latch base and len. If len==0, go to DONE; otherwise clear words_written and go to FILL.
  - FILL: s_ready=1. Each s_valid&s_ready handshake stores s_data into lane lane_idx of the word register, sets the matching bit of the pending byteenable, increments lane_idx, and decrements the remaining count. When lane_idx reaches 3, or the byte just accepted is the last one, go to WRITE on the next cycle.
  - WRITE: exactly one cycle with s_ready=0 and mem_chipselect=mem_write=1. mem_address=current address; mem_byteenable=filled lanes (4'b1111 for a full word; 4'b0001/0011/0111 for a final partial word). Unfilled lanes of mem_writedata are driven 0. Then: address+1, words_written+1, lane_idx=0, pending byteenable cleared. Go to DONE if the remaining count is 0, else to FILL.
  - DONE: done=1 for one cycle, then return to IDLE.
- busy=1 in FILL, WRITE and DONE.
- All mem_* outputs are registered. The write occurs in the cycle after the 4th byte handshake, so latency is 1 clk from the last byte to the RAM write strobe. Throughput is 4 bytes per 5 clks.
- mem_chipselect/mem_write are 0 outside WRITE. The loader never reads and does not drive the RAM clken; the top level ties the RAM clken to 1.
- The address increments modulo 2**ADDR_W, so writing past the top of RAM wraps to 0 silently.
- cfg_start while busy is ignored; the latched parameters are unchanged.
- s_valid in IDLE/WRITE/DONE is not consumed (s_ready=0); the byte is held upstream.
- s_data is sampled only on a handshake; s_data is don't-care when s_valid=0.
- Reset assertion mid-transfer aborts immediately: outputs return to reset values, the partial word is discarded, and no write is issued.

Decomposition:
- Shared package: state encoding enum (IDLE, FILL, WRITE, DONE) and the LANE_FULL=4'b1111 constant.
- One sub-module is natural: sopc_byte_packer, holding the lane index, the byte shift-in into the 32-bit register, and byteenable accumulation. Its inputs are load, clear and byte; its outputs are word, be and full.
- The FSM and the address/length counters stay in the top module.

Test Plan:
- Base 0x010, len 8, bytes 0x11..0x88 streamed with no gaps -> writes 0x44332211 @0x010 be=1111 and 0x88776655 @0x011 be=1111; done pulses once; words_written=2; s_ready low exactly 1 cycle after each 4th byte.
- Base 0x020, len 6, bytes A0..A5 -> 0xA3A2A1A0 @0x020 be=1111, then 0x0000A5A4 @0x021 be=0011.
- Base 0xFFF, len 8 -> first write @0xFFF, second write @0x000 (wrap).
- Len 0 -> no mem_write; busy high for 1 cycle; done 1 cycle after cfg_start.
- s_valid toggled randomly at 30% duty, plus cfg_start pulsed mid-transfer with a different base -> written data/addresses identical to the gap-free run; second start ignored.
- reset_n asserted after 2 bytes of a len-4 transfer -> no write issued; all outputs 0; a new transfer after reset writes correctly from lane 0.

Source files
------------

// File: rtl/sopc_mem_byte_loader_pkg.sv
// sopc_mem_byte_loader_pkg: shared state encoding and lane constants for the byte loader
package sopc_mem_byte_loader_pkg;
    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;
    localparam logic [3:0] LANE_FULL = 4'b1111;
endpackage

// File: rtl/sopc_byte_packer.sv
// sopc_byte_packer: shifts bytes little-endian into a 32-bit word and accumulates lane enables
module sopc_byte_packer
    import sopc_mem_byte_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic        clear,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic [3:0]  be,
    output logic        full
);
    logic [1:0]  lane_q, lane_d;
    logic [31:0] word_q, word_d;
    logic [3:0]  be_q, be_d;
    always_comb begin
        lane_d = lane_q;
        word_d = word_q;
        be_d   = be_q;
        if (clear) begin
            lane_d = '0;
            word_d = '0;
            be_d   = '0;
        end else if (load) begin
            word_d[{lane_q, 3'b000} +: 8] = data;
            be_d[lane_q]                  = 1'b1;
            lane_d                        = lane_q + 2'd1;
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane_q <= '0;
            word_q <= '0;
            be_q   <= '0;
        end else begin
            lane_q <= lane_d;
            word_q <= word_d;
            be_q   <= be_d;
        end
    end
    // full means the next accepted byte completes the word
    assign full = ({1'b1, be_q[2:0]} == LANE_FULL);
    assign word = word_q;
    assign be   = be_q;
endmodule

// File: rtl/sopc_mem_byte_loader.sv
// sopc_mem_byte_loader: packs a byte stream into 32-bit RAM writes with auto-increment addressing
module sopc_mem_byte_loader
    import sopc_mem_byte_loader_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_start,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [LEN_W-1:0]  cfg_len_bytes,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_written
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic              wr_q, wr_d;
    logic              load, clear, full;
    logic [31:0]       word;
    logic [3:0]        be;

    sopc_byte_packer u_packer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .clear   (clear),
        .data    (s_data),
        .word    (word),
        .be      (be),
        .full    (full)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        words_d = words_q;
        wr_d    = 1'b0;
        load    = 1'b0;
        clear   = 1'b0;
        case (state_q)
            IDLE: if (cfg_start) begin
                addr_d  = cfg_base_addr;
                rem_d   = cfg_len_bytes;
                words_d = (cfg_len_bytes == '0) ? words_q : '0;
                state_d = (cfg_len_bytes == '0) ? DONE : FILL;
            end
            FILL: if (s_valid) begin
                load  = 1'b1;
                rem_d = rem_q - LEN_W'(1);
                if (full || rem_q == LEN_W'(1)) begin
                    state_d = WRITE;
                    wr_d    = 1'b1;
                end
            end
            WRITE: begin
                clear   = 1'b1;
                addr_d  = addr_q + ADDR_W'(1);
                words_d = words_q + (ADDR_W+1)'(1);
                state_d = (rem_q == '0) ? DONE : FILL;
            end
            DONE: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            words_q <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            words_q <= words_d;
            wr_q    <= wr_d;
        end
    end

    assign s_ready        = (state_q == FILL);
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign mem_write      = wr_q;
    assign mem_chipselect = wr_q;
    assign mem_address    = addr_q;
    assign mem_byteenable = wr_q ? be : 4'b0000;
    assign mem_writedata  = word;
    assign words_written  = words_q;
endmodule

// File: tb/tb_sopc_mem_byte_loader.sv
// tb_sopc_mem_byte_loader: directed self-checking bench for the byte loader
module tb_sopc_mem_byte_loader;
    logic        clk = 1'b0, reset_n = 1'b0, cfg_start = 1'b0, s_valid = 1'b0;
    logic [11:0] cfg_base_addr = '0;
    logic [14:0] cfg_len_bytes = '0;
    logic [7:0]  s_data = '0;
    logic        s_ready, mem_chipselect, mem_write, busy, done;
    logic [11:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic [12:0] words_written;

    sopc_mem_byte_loader dut (
        .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
        .cfg_len_bytes(cfg_len_bytes), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_writedata(mem_writedata), .busy(busy), .done(done),
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    int vecs = 0, errs = 0, cyc = 0, done_cnt = 0, busy_cnt = 0;
    logic [11:0] wa[$];
    logic [31:0] wd[$];
    logic [3:0]  wb[$];
    int          wc[$], hc[$];
    logic [7:0]  src[16];
    int          nsrc;

    always @(negedge clk) begin
        if (mem_write && mem_chipselect) begin
            wa.push_back(mem_address);
            wd.push_back(mem_writedata);
            wb.push_back(mem_byteenable);
            wc.push_back(cyc);
        end
        if (s_valid && s_ready) hc.push_back(cyc);
        if (done) done_cnt++;
        if (busy) busy_cnt++;
        cyc++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [11:0] b, input logic [14:0] l);
        cfg_base_addr = b;
        cfg_len_bytes = l;
        cfg_start     = 1'b1;
        step;
        cfg_start     = 1'b0;
    endtask

    task automatic stream(input int duty, input bit mid);
        int idx = 0, t = 0;
        bit hs, sent = 0;
        while (idx < nsrc && t < 2000) begin
            s_valid = (duty >= 100) || ($urandom_range(0, 99) < duty);
            s_data  = s_valid ? src[idx] : 8'hEE;
            if (mid && idx == 3 && !sent) begin
                sent          = 1;
                cfg_start     = 1'b1;
                cfg_base_addr = 12'h300;
                cfg_len_bytes = 15'd4;
            end
            hs = s_valid && s_ready;
            step;
            cfg_start = 1'b0;
            if (hs) idx++;
            t++;
        end
        s_valid = 1'b0;
        vecs++;
        if (idx != nsrc) begin errs++; $display("FAIL stream_timeout: got %0d bytes, want %0d", idx, nsrc); end
    endtask

    task automatic wait_done(input int d0);
        int t = 0;
        while (done_cnt == d0 && t < 100) begin step; t++; end
        step;
        vecs++;
        if (done_cnt == d0) begin errs++; $display("FAIL done_timeout: got no done pulse, want one"); end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        step;
        step;
        reset_n = 1'b1;
        step;
        vecs++;
        if ({s_ready, busy, done, mem_write, mem_chipselect, mem_address, mem_byteenable, mem_writedata, words_written} !== '0) begin
            errs++;
            $display("FAIL reset_outputs: got busy=%b ready=%b wr=%b addr=%h data=%h ww=%0d, want all 0",
                     busy, s_ready, mem_write, mem_address, mem_writedata, words_written);
        end
    endtask

    task automatic run_8_bytes(input string name, input int duty, input bit mid);
        int w0 = wa.size(), h0 = hc.size(), d0 = done_cnt;
        nsrc = 8;
        for (int i = 0; i < 8; i++) src[i] = 8'(8'h11 * (i + 1));
        start(12'h010, 15'd8);
        stream(duty, mid);
        wait_done(d0);
        vecs++;
        if (wa.size() - w0 != 2) begin errs++; $display("FAIL %s_count: got %0d writes, want 2", name, wa.size() - w0); end
        vecs++;
        if ({wa[w0], wd[w0], wb[w0]} !== {12'h010, 32'h44332211, 4'hF}) begin
            errs++;
            $display("FAIL %s_w0: got %h/%h/%b, want 010/44332211/1111", name, wa[w0], wd[w0], wb[w0]);
        end
        vecs++;
        if ({wa[w0+1], wd[w0+1], wb[w0+1]} !== {12'h011, 32'h88776655, 4'hF}) begin
            errs++;
            $display("FAIL %s_w1: got %h/%h/%b, want 011/88776655/1111", name, wa[w0+1], wd[w0+1], wb[w0+1]);
        end
        vecs++;
        if (done_cnt - d0 != 1) begin errs++; $display("FAIL %s_done: got %0d pulses, want 1", name, done_cnt - d0); end
        vecs++;
        if (words_written !== 13'd2) begin errs++; $display("FAIL %s_words: got %0d, want 2", name, words_written); end
        if (duty >= 100) begin
            vecs++;
            if (wc[w0] != hc[h0+3] + 1) begin
                errs++;
                $display("FAIL %s_latency: got write at %0d, want %0d", name, wc[w0], hc[h0+3] + 1);
            end
            vecs++;
            if (hc[h0+4] != hc[h0+3] + 2) begin
                errs++;
                $display("FAIL %s_ready_gap: got next byte at %0d, want %0d", name, hc[h0+4], hc[h0+3] + 2);
            end
        end
    endtask

    task automatic test_full_words;
        run_8_bytes("full", 100, 0);
    endtask

    task automatic test_gaps_restart;
        run_8_bytes("gaps", 30, 1);
    endtask

    task automatic test_partial;
        int w0 = wa.size(), d0 = done_cnt;
        nsrc = 6;
        for (int i = 0; i < 6; i++) src[i] = 8'(8'hA0 + i);
        start(12'h020, 15'd6);
        stream(100, 0);
        wait_done(d0);
        vecs++;
        if (wa.size() - w0 != 2) begin errs++; $display("FAIL partial_count: got %0d writes, want 2", wa.size() - w0); end
        vecs++;
        if ({wa[w0], wd[w0], wb[w0]} !== {12'h020, 32'hA3A2A1A0, 4'hF}) begin
            errs++;
            $display("FAIL partial_w0: got %h/%h/%b, want 020/a3a2a1a0/1111", wa[w0], wd[w0], wb[w0]);
        end
        vecs++;
        if ({wa[w0+1], wd[w0+1], wb[w0+1]} !== {12'h021, 32'h0000A5A4, 4'b0011}) begin
            errs++;
            $display("FAIL partial_w1: got %h/%h/%b, want 021/0000a5a4/0011", wa[w0+1], wd[w0+1], wb[w0+1]);
        end
    endtask

    task automatic test_wrap;
        int w0 = wa.size(), d0 = done_cnt;
        nsrc = 8;
        for (int i = 0; i < 8; i++) src[i] = 8'(i + 1);
        start(12'hFFF, 15'd8);
        stream(100, 0);
        wait_done(d0);
        vecs++;
        if ({wa[w0], wd[w0]} !== {12'hFFF, 32'h04030201}) begin
            errs++;
            $display("FAIL wrap_w0: got %h/%h, want fff/04030201", wa[w0], wd[w0]);
        end
        vecs++;
        if ({wa[w0+1], wd[w0+1]} !== {12'h000, 32'h08070605}) begin
            errs++;
            $display("FAIL wrap_w1: got %h/%h, want 000/08070605", wa[w0+1], wd[w0+1]);
        end
    endtask

    task automatic test_len_zero;
        int w0 = wa.size(), b0 = busy_cnt;
        start(12'h100, 15'd0);
        vecs++;
        if ({busy, done} !== 2'b11) begin errs++; $display("FAIL len0_done: got busy=%b done=%b, want 1 1", busy, done); end
        step;
        vecs++;
        if ({busy, done} !== 2'b00) begin errs++; $display("FAIL len0_idle: got busy=%b done=%b, want 0 0", busy, done); end
        vecs++;
        if (busy_cnt - b0 != 1) begin errs++; $display("FAIL len0_busy: got %0d cycles, want 1", busy_cnt - b0); end
        vecs++;
        if (wa.size() != w0) begin errs++; $display("FAIL len0_nowrite: got %0d writes, want 0", wa.size() - w0); end
    endtask

    task automatic test_reset_abort;
        int w0 = wa.size(), d0;
        nsrc = 2;
        src[0] = 8'h5A;
        src[1] = 8'h5B;
        start(12'h200, 15'd4);
        stream(100, 0);
        reset_n = 1'b0;
        #2;
        vecs++;
        if ({s_ready, busy, done, mem_write, mem_chipselect, mem_address, mem_byteenable, mem_writedata, words_written} !== '0) begin
            errs++;
            $display("FAIL abort_outputs: got busy=%b ready=%b addr=%h data=%h ww=%0d, want all 0",
                     busy, s_ready, mem_address, mem_writedata, words_written);
        end
        step;
        reset_n = 1'b1;
        step;
        vecs++;
        if (wa.size() != w0) begin errs++; $display("FAIL abort_nowrite: got %0d writes, want 0", wa.size() - w0); end
        d0 = done_cnt;
        nsrc = 4;
        for (int i = 0; i < 4; i++) src[i] = 8'(i + 1);
        start(12'h055, 15'd4);
        stream(100, 0);
        wait_done(d0);
        vecs++;
        if ({wa[w0], wd[w0], wb[w0]} !== {12'h055, 32'h04030201, 4'hF} || wa.size() - w0 != 1) begin
            errs++;
            $display("FAIL abort_restart: got %h/%h/%b n=%0d, want 055/04030201/1111 n=1", wa[w0], wd[w0], wb[w0], wa.size() - w0);
        end
        vecs++;
        if (words_written !== 13'd1) begin errs++; $display("FAIL abort_words: got %0d, want 1", words_written); end
    endtask

    initial begin
        test_reset;
        test_full_words;
        test_partial;
        test_wrap;
        test_len_zero;
        test_gaps_restart;
        test_reset_abort;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
